spi_bus_arbiter: RTL and testbench

//  Shares the single byte-level SPI master between the SD card, flash and LCD clients.

---
 rtl/spi_bus_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bus_arbiter.sv
// Round-robin, per-burst arbiter sharing one byte-level SPI master between sdcard, flash and lcd.
// Optional watchdog abort of stalled bursts is compiled in with `define SPI_ARB_TIMEOUT_EN.
module spi_bus_arbiter #(
    parameter int unsigned N_REQ          = 3,
    parameter int unsigned CS_GAP_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic               Bus2IP_Clk,
    input  logic               Bus2IP_Resetn,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ-1:0]   req_last,
    input  logic [N_REQ-1:0]   req_cd,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic               rsp_valid,
    output logic [N_REQ-1:0]   rsp_id,
    output logic [7:0]         rsp_data,
    output logic               spi_start,
    output logic [7:0]         spi_data_out,
    output logic               spi_cd,
    output logic [2:0]         spi_cs_sel,
    input  logic               spi_busy,
    input  logic               spi_done,
    input  logic [7:0]         spi_rx_data,
    output logic               arb_err
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SETUP     = 3'd1;
    localparam logic [2:0] S_LOAD      = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_HOLD      = 3'd4;
    localparam logic [2:0] S_GAP       = 3'd5;

    localparam int unsigned GAP_W = $clog2(CS_GAP_CYCLES + 1);

    if (N_REQ != 3 || CS_GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("spi_bus_arbiter: unsupported parameter set");
    end

    logic [2:0]       state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       rr_q, rr_d;
    logic [2:0]       cs_q, cs_d;
    logic             last_q, last_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [7:0]       data_q, data_d;
    logic             cd_q, cd_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [N_REQ-1:0] rsp_id_q, rsp_id_d;
    logic [7:0]       rsp_data_q, rsp_data_d;

    logic       any_req;
    logic [1:0] pick;
    logic [1:0] idx;
    logic       own_valid, own_last, own_cd;
    logic [7:0] own_data;
    logic       start;
    logic       tmo_hit;

    // Chip-select and response-id share the master's encoding: sdcard on the MSB.
    function automatic logic [2:0] cs_code(input logic [1:0] id);
        case (id)
            2'd0:    cs_code = 3'b100;
            2'd1:    cs_code = 3'b010;
            2'd2:    cs_code = 3'b001;
            default: cs_code = 3'b000;
        endcase
    endfunction

    always_comb begin
        any_req = 1'b0;
        pick    = '0;
        idx     = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = 2'((32'(rr_q) + k) % N_REQ);
            if (!any_req && req_valid[idx]) begin
                any_req = 1'b1;
                pick    = idx;
            end
        end
    end

    assign own_valid = req_valid[owner_q];
    assign own_last  = req_last[owner_q];
    assign own_cd    = req_cd[owner_q];
    assign own_data  = req_data[{owner_q, 3'b000} +: 8];

    // The start cycle presents the owner's byte directly; the registers hold it afterwards.
    assign start        = (state_q == S_LOAD) && !spi_busy && own_valid;
    assign spi_start    = start;
    assign spi_data_out = start ? own_data : data_q;
    assign spi_cd       = start ? own_cd : cd_q;
    assign req_ready    = start ? (N_REQ'(1) << owner_q) : '0;
    assign spi_cs_sel   = cs_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_data     = rsp_data_q;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    assign tmo_hit = ((state_q == S_WAIT_DONE) || (state_q == S_HOLD)) &&
                     (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign arb_err = tmo_hit;

    // Any state change (including WAIT_DONE -> HOLD) restarts the count.
    always_comb begin
        tmo_d = '0;
        if (((state_q == S_WAIT_DONE) || (state_q == S_HOLD)) && (state_d == state_q)) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign arb_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        cs_d        = cs_q;
        last_d      = last_q;
        gap_d       = gap_q;
        data_d      = data_q;
        cd_d        = cd_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    owner_d = pick;
                    cs_d    = cs_code(pick);
                    state_d = S_SETUP;
                end
            end
            S_SETUP: state_d = S_LOAD;
            S_LOAD: begin
                if (start) begin
                    data_d  = own_data;
                    cd_d    = own_cd;
                    last_d  = own_last;
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!tmo_hit && spi_done) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = spi_rx_data;
                    rsp_id_d    = cs_code(owner_q);
                    state_d     = last_q ? S_GAP : S_HOLD;
                end
            end
            S_HOLD: begin
                if (!tmo_hit && own_valid) begin
                    state_d = S_LOAD;
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Every path into GAP (normal end or watchdog abort) releases CS and advances rr.
        if ((state_d == S_GAP) && (state_q != S_GAP)) begin
            state_d = S_GAP;
            cs_d    = '0;
            gap_d   = GAP_W'(CS_GAP_CYCLES - 1);
            rr_d    = (owner_q == 2'd2) ? 2'd0 : owner_q + 2'd1;
        end
        if (tmo_hit) begin
            state_d = S_GAP;
            cs_d    = '0;
            gap_d   = GAP_W'(CS_GAP_CYCLES - 1);
            rr_d    = (owner_q == 2'd2) ? 2'd0 : owner_q + 2'd1;
        end
    end

    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            state_q     <= S_IDLE;
            owner_q     <= '0;
            rr_q        <= '0;
            cs_q        <= '0;
            last_q      <= 1'b0;
            gap_q       <= '0;
            data_q      <= '0;
            cd_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            cs_q        <= cs_d;
            last_q      <= last_d;
            gap_q       <= gap_d;
            data_q      <= data_d;
            cd_q        <= cd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: bench-side client and SPI master models, per-scenario checks.
// The watchdog scenario runs only when SPI_ARB_TIMEOUT_EN is defined.
module tb_spi_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_valid, req_last, req_cd, req_ready;
    logic [23:0] req_data;
    logic        rsp_valid;
    logic [2:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic        spi_start;
    logic [7:0]  spi_data_out;
    logic        spi_cd;
    logic [2:0]  spi_cs_sel;
    logic        spi_busy, spi_done;
    logic [7:0]  spi_rx_data;
    logic        arb_err;

    int checks = 0;
    int failures = 0;

    int         cl_n[3];
    logic [7:0] cl_byte[3];
    logic       cl_cd[3];
    logic       cl_single[3];
    int         mst_cnt;
    int         mst_lat;
    logic [7:0] mst_rx;
    logic       force_done;

    logic [2:0] log_cs[$];
    logic [7:0] log_data[$];
    logic       log_cd[$];
    logic [2:0] log_rid[$];
    logic [7:0] log_rdata[$];

    always #5 clk = ~clk;

    spi_bus_arbiter #(.N_REQ(3), .CS_GAP_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
        .Bus2IP_Clk(clk), .Bus2IP_Resetn(rst_n),
        .req_valid(req_valid), .req_last(req_last), .req_cd(req_cd), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .spi_start(spi_start), .spi_data_out(spi_data_out), .spi_cd(spi_cd),
        .spi_cs_sel(spi_cs_sel), .spi_busy(spi_busy), .spi_done(spi_done),
        .spi_rx_data(spi_rx_data), .arb_err(arb_err)
    );

    // One clock of bench activity: inputs change at the falling edge, outputs read 1 time unit later.
    task automatic tick();
        @(negedge clk);
        spi_done   = force_done;
        force_done = 1'b0;
        if (mst_cnt > 0) begin
            mst_cnt--;
            if (mst_cnt == 0) begin
                spi_done    = 1'b1;
                spi_busy    = 1'b0;
                spi_rx_data = mst_rx;
                mst_rx      = mst_rx + 8'd1;
            end else begin
                spi_busy = 1'b1;
            end
        end
        for (int i = 0; i < 3; i++) begin
            req_valid[i]       = (cl_n[i] > 0);
            req_last[i]        = cl_single[i] || (cl_n[i] == 1);
            req_cd[i]          = cl_cd[i];
            req_data[8*i +: 8] = cl_byte[i];
        end
        #1;
        if (spi_start) begin
            mst_cnt = mst_lat;
            log_cs.push_back(spi_cs_sel);
            log_data.push_back(spi_data_out);
            log_cd.push_back(spi_cd);
        end
        if (rsp_valid) begin
            log_rid.push_back(rsp_id);
            log_rdata.push_back(rsp_data);
        end
        for (int i = 0; i < 3; i++) begin
            if (req_ready[i]) begin
                cl_n[i]--;
                cl_byte[i] = cl_byte[i] + 8'd1;
            end
        end
    endtask

    task automatic clear_logs();
        log_cs.delete(); log_data.delete(); log_cd.delete();
        log_rid.delete(); log_rdata.delete();
    endtask

    task automatic clear_stim();
        for (int i = 0; i < 3; i++) begin
            cl_n[i] = 0; cl_byte[i] = 8'h00; cl_cd[i] = 1'b0; cl_single[i] = 1'b0;
        end
        mst_cnt = 0; mst_lat = 3; mst_rx = 8'h00; force_done = 1'b0;
        spi_busy = 1'b0; spi_done = 1'b0; spi_rx_data = 8'h00;
        req_valid = '0; req_last = '0; req_cd = '0; req_data = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_stim();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int quiet;
        quiet = 0;
        for (int t = 0; t < 500 && quiet < 8; t++) begin
            tick();
            if (cl_n[0] == 0 && cl_n[1] == 0 && cl_n[2] == 0 && mst_cnt == 0 && spi_cs_sel == 3'b000)
                quiet++;
            else
                quiet = 0;
        end
        checks++;
        if (quiet < 8) begin
            failures++;
            $display("FAIL drain: bus not idle within bound, cs=%b pending=%0d/%0d/%0d",
                     spi_cs_sel, cl_n[0], cl_n[1], cl_n[2]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_stim();
        req_valid = 3'b111; req_last = 3'b111; req_data = 24'hFFFFFF;
        spi_done = 1'b1; spi_rx_data = 8'h5A;
        #22;
        checks++;
        if (spi_cs_sel !== 3'b000) begin
            failures++;
            $display("FAIL reset_cs: got %b expected 000", spi_cs_sel);
        end
        checks++;
        if ({req_ready, rsp_valid, rsp_id, rsp_data, spi_start, spi_data_out, spi_cd, arb_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b rv=%b rid=%b rd=%h st=%b do=%h cd=%b err=%b expected all 0",
                     req_ready, rsp_valid, rsp_id, rsp_data, spi_start, spi_data_out, spi_cd, arb_err);
        end
        clear_stim();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_byte();
        int t_start, t_rsp, gap_bad;
        t_start = -1; t_rsp = -1; gap_bad = 0;
        clear_logs();
        cl_n[2] = 1; cl_byte[2] = 8'hA5; cl_cd[2] = 1'b1; cl_single[2] = 1'b1;
        mst_lat = 200; mst_rx = 8'h3C;
        for (int t = 0; t < 260; t++) begin
            tick();
            if (t == 1) begin
                checks++;
                if (spi_cs_sel !== 3'b001) begin
                    failures++;
                    $display("FAIL single_setup_cs: got %b expected 001", spi_cs_sel);
                end
            end
            if (spi_start) begin
                t_start = t;
                checks++;
                if (req_ready !== 3'b100) begin
                    failures++;
                    $display("FAIL single_ready: got %b expected 100", req_ready);
                end
            end
            if (rsp_valid && t_rsp < 0) t_rsp = t;
            if (t_rsp >= 0 && t < t_rsp + 4 && spi_cs_sel !== 3'b000) gap_bad++;
        end
        checks++;
        if (t_start !== 2) begin
            failures++;
            $display("FAIL single_latency: start at cycle %0d expected 2", t_start);
        end
        checks++;
        if ({log_cs[0], log_data[0], log_cd[0]} !== {3'b001, 8'hA5, 1'b1}) begin
            failures++;
            $display("FAIL single_start: got cs=%b data=%h cd=%b expected cs=001 data=a5 cd=1",
                     log_cs[0], log_data[0], log_cd[0]);
        end
        checks++;
        if (t_rsp !== t_start + 201) begin
            failures++;
            $display("FAIL single_rsp_time: rsp at %0d expected %0d", t_rsp, t_start + 201);
        end
        checks++;
        if ({log_rid.size() == 1, log_rid[0], log_rdata[0]} !== {1'b1, 3'b001, 8'h3C}) begin
            failures++;
            $display("FAIL single_rsp: got n=%0d id=%b data=%h expected n=1 id=001 data=3c",
                     log_rid.size(), log_rid[0], log_rdata[0]);
        end
        checks++;
        if (gap_bad !== 0) begin
            failures++;
            $display("FAIL single_gap: %0d gap cycles with CS asserted, expected 0", gap_bad);
        end
    endtask

    task automatic test_burst_lock();
        int t3, t_sd, hold_bad, gap_bad;
        t3 = -1; t_sd = -1; hold_bad = 0; gap_bad = 0;
        clear_logs();
        cl_n[1] = 3; cl_byte[1] = 8'h10; cl_cd[1] = 1'b0; cl_single[1] = 1'b0;
        mst_lat = 5; mst_rx = 8'h40;
        for (int t = 0; t < 150; t++) begin
            tick();
            if (t == 0) begin
                cl_n[0] = 1; cl_byte[0] = 8'h20; cl_cd[0] = 1'b1; cl_single[0] = 1'b1;
            end
            if (log_cs.size() >= 1 && log_rid.size() < 3 && spi_cs_sel !== 3'b010) hold_bad++;
            if (log_rid.size() == 3 && t3 < 0) t3 = t;
            if (t3 >= 0 && t < t3 + 4 && spi_cs_sel !== 3'b000) gap_bad++;
            if (spi_start && spi_cs_sel == 3'b100 && t_sd < 0) t_sd = t;
        end
        checks++;
        if ({log_cs[0], log_cs[1], log_cs[2], log_cs[3]} !== 12'b010_010_010_100) begin
            failures++;
            $display("FAIL burst_grants: got %b %b %b %b expected 010 010 010 100",
                     log_cs[0], log_cs[1], log_cs[2], log_cs[3]);
        end
        checks++;
        if ({log_data[0], log_data[1], log_data[2], log_data[3]} !== 32'h10111220) begin
            failures++;
            $display("FAIL burst_data: got %h %h %h %h expected 10 11 12 20",
                     log_data[0], log_data[1], log_data[2], log_data[3]);
        end
        checks++;
        if ({log_rid[0], log_rid[1], log_rid[2], log_rid[3], log_rdata[0], log_rdata[3]} !==
            {12'b010_010_010_100, 8'h40, 8'h43}) begin
            failures++;
            $display("FAIL burst_rsp: got ids %b %b %b %b first=%h last=%h expected 010 010 010 100 40 43",
                     log_rid[0], log_rid[1], log_rid[2], log_rid[3], log_rdata[0], log_rdata[3]);
        end
        checks++;
        if (hold_bad !== 0) begin
            failures++;
            $display("FAIL burst_cs_hold: %0d cycles without flash CS, expected 0", hold_bad);
        end
        checks++;
        if (gap_bad !== 0 || t_sd !== t3 + 6) begin
            failures++;
            $display("FAIL burst_gap: gap_bad=%0d sdcard start=%0d expected 0 and %0d", gap_bad, t_sd, t3 + 6);
        end
        drain();
    endtask

    task automatic test_round_robin();
        do_reset();
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            cl_n[i] = 2; cl_single[i] = 1'b1; cl_cd[i] = 1'b0;
        end
        cl_byte[0] = 8'h30; cl_byte[1] = 8'h50; cl_byte[2] = 8'h70;
        mst_lat = 3; mst_rx = 8'h80;
        for (int t = 0; t < 200; t++) tick();
        checks++;
        if ({log_cs.size() == 6, log_cs[0], log_cs[1], log_cs[2], log_cs[3], log_cs[4], log_cs[5]} !==
            {1'b1, 18'b100_010_001_100_010_001}) begin
            failures++;
            $display("FAIL rr_order: got n=%0d %b %b %b %b %b %b expected 100 010 001 100 010 001",
                     log_cs.size(), log_cs[0], log_cs[1], log_cs[2], log_cs[3], log_cs[4], log_cs[5]);
        end
        checks++;
        if ({log_data[0], log_data[1], log_data[2], log_data[3], log_data[4], log_data[5]} !== 48'h305070315171) begin
            failures++;
            $display("FAIL rr_data: got %h %h %h %h %h %h expected 30 50 70 31 51 71",
                     log_data[0], log_data[1], log_data[2], log_data[3], log_data[4], log_data[5]);
        end
        checks++;
        if ({log_rid[0], log_rid[1], log_rid[2], log_rid[3], log_rid[4], log_rid[5], log_rdata[5]} !==
            {18'b100_010_001_100_010_001, 8'h85}) begin
            failures++;
            $display("FAIL rr_rsp: got %b %b %b %b %b %b last=%h expected 100 010 001 100 010 001 last=85",
                     log_rid[0], log_rid[1], log_rid[2], log_rid[3], log_rid[4], log_rid[5], log_rdata[5]);
        end
        drain();
    endtask

    task automatic test_load_drop();
        int bad;
        bad = 0;
        clear_logs();
        cl_n[0] = 1; cl_byte[0] = 8'h90; cl_single[0] = 1'b1;
        mst_lat = 3; mst_rx = 8'h00;
        tick();
        cl_n[0] = 0;
        cl_n[1] = 1; cl_byte[1] = 8'hA0; cl_single[1] = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (spi_start || spi_cs_sel !== 3'b100) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL load_drop_stall: %0d cycles with start or CS change, expected 0", bad);
        end
        cl_n[0] = 1;
        tick();
        checks++;
        if ({spi_start, spi_cs_sel, spi_data_out} !== {1'b1, 3'b100, 8'h90}) begin
            failures++;
            $display("FAIL load_drop_resume: got start=%b cs=%b data=%h expected 1 100 90",
                     spi_start, spi_cs_sel, spi_data_out);
        end
        drain();
    endtask

    task automatic test_stray_done();
        clear_logs();
        spi_rx_data = 8'hEE;
        force_done = 1'b1;
        repeat (3) tick();
        checks++;
        if (log_rid.size() !== 0) begin
            failures++;
            $display("FAIL stray_done: got %0d responses expected 0", log_rid.size());
        end
    endtask

    task automatic test_mid_reset();
        int seen, t_first;
        seen = -1; t_first = -1;
        do_reset();
        cl_n[1] = 1; cl_byte[1] = 8'hE0; cl_single[1] = 1'b1;
        mst_lat = 2;
        drain();
        clear_logs();
        cl_n[2] = 1; cl_byte[2] = 8'hE8; cl_single[2] = 1'b1;
        mst_lat = 1000;
        for (int t = 0; t < 30; t++) begin
            tick();
            if (spi_start) seen = t;
            if (seen >= 0 && t == seen + 5) break;
        end
        checks++;
        if (spi_cs_sel !== 3'b001) begin
            failures++;
            $display("FAIL midrst_pre_cs: got %b expected 001", spi_cs_sel);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({spi_cs_sel, spi_start, rsp_valid, req_ready, spi_data_out, spi_cd, rsp_id, rsp_data} !== '0) begin
            failures++;
            $display("FAIL midrst_outputs: got cs=%b st=%b rv=%b rdy=%b do=%h cd=%b rid=%b rd=%h expected all 0",
                     spi_cs_sel, spi_start, rsp_valid, req_ready, spi_data_out, spi_cd, rsp_id, rsp_data);
        end
        clear_stim();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            cl_n[i] = 1; cl_single[i] = 1'b1;
        end
        cl_byte[0] = 8'hB0; cl_byte[1] = 8'hC0; cl_byte[2] = 8'hD0;
        mst_lat = 3;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (spi_start && t_first < 0) t_first = t;
        end
        checks++;
        if ({t_first == 2, log_cs[0], log_data[0]} !== {1'b1, 3'b100, 8'hB0}) begin
            failures++;
            $display("FAIL midrst_regrant: got t=%0d cs=%b data=%h expected t=2 cs=100 data=b0",
                     t_first, log_cs[0], log_data[0]);
        end
        drain();
    endtask

`ifdef SPI_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int t_s, t_err, n_err, t_fl;
        logic [2:0] cs_after;
        t_s = -1; t_err = -1; n_err = 0; t_fl = -1; cs_after = 3'bxxx;
        do_reset();
        clear_logs();
        cl_n[0] = 1; cl_byte[0] = 8'h11; cl_single[0] = 1'b1;
        cl_n[1] = 1; cl_byte[1] = 8'h22; cl_single[1] = 1'b1;
        mst_lat = 100000; mst_rx = 8'h66;
        for (int t = 0; t < 60; t++) begin
            tick();
            if (spi_start && t_s < 0) t_s = t;
            if (spi_start && spi_cs_sel == 3'b010) t_fl = t;
            if (t_err >= 0 && t == t_err + 1) cs_after = spi_cs_sel;
            if (arb_err) begin
                n_err++;
                t_err = t;
                mst_cnt = 0; spi_busy = 1'b0; mst_lat = 3;
            end
        end
        checks++;
        if ({n_err == 1, t_err == t_s + 16} !== 2'b11) begin
            failures++;
            $display("FAIL timeout_err: got %0d pulses at %0d expected 1 at %0d", n_err, t_err, t_s + 16);
        end
        checks++;
        if (cs_after !== 3'b000) begin
            failures++;
            $display("FAIL timeout_cs: got %b expected 000", cs_after);
        end
        checks++;
        if ({t_fl == t_err + 7, log_rid.size() == 1, log_rid[0]} !== {2'b11, 3'b010}) begin
            failures++;
            $display("FAIL timeout_next: flash start %0d rsp n=%0d id=%b expected start %0d n=1 id=010",
                     t_fl, log_rid.size(), log_rid[0], t_err + 7);
        end
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_single_byte();
        test_burst_lock();
        test_round_robin();
        test_load_drop();
        test_stray_done();
        test_mid_reset();
`ifdef SPI_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
